hpdcache_mem_rw_mux: RTL and testbench

// Downstream of the HPDcache memory interface. Merges the cache's read-request channel and its

---
 rtl/hpdcache_mem_mux_pkg.sv | 24 ++
 rtl/hpdcache_mem_req_slice.sv | 31 +++
 rtl/hpdcache_mem_rw_mux.sv | 164 ++++++++++++++++
 tb/tb_hpdcache_mem_rw_mux.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_mem_mux_pkg.sv
// Shared types for the HPDcache memory read/write request merger.
package hpdcache_mem_mux_pkg;

  // Which side of the cache owns a request; also the round-robin pointer value
  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  localparam int unsigned DEF_ADDR_W    = 56;
  localparam int unsigned DEF_ID_W      = 6;
  localparam int unsigned DEF_DATA_W    = 512;
  localparam int unsigned DEF_MAX_OUTST = 8;

  // Merged request at the default widths; the top re-declares it at its own widths
  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_ID_W-1:0]       id;
    logic [DEF_DATA_W-1:0]     data;
    logic [DEF_DATA_W/8-1:0]   be;
  } mem_req_s;

endpackage

// File: rtl/hpdcache_mem_req_slice.sv
// One-entry registered valid/ready stage for the merged memory request.
module hpdcache_mem_req_slice #(
  parameter type req_t = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid,
  output logic in_ready,
  input  req_t in_req,
  output logic out_valid,
  input  logic out_ready,
  output req_t out_req
);

  // The slot can take a new entry when empty or when its entry leaves this cycle
  assign in_ready = !out_valid || out_ready;

  // Capture on accept, hold while stalled, empty once the consumer takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_req   <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_req   <= in_req;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hpdcache_mem_rw_mux.sv
// Merges HPDcache read and write request channels onto one memory request bus,
// demultiplexes memory responses by opcode, and bounds in-flight transactions.
module hpdcache_mem_rw_mux
  import hpdcache_mem_mux_pkg::*;
#(
  parameter int unsigned ADDR_W    = 56,
  parameter int unsigned ID_W      = 6,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rd_req_valid_i,
  output logic                rd_req_ready_o,
  input  logic [ADDR_W-1:0]   rd_req_addr_i,
  input  logic [ID_W-1:0]     rd_req_id_i,
  input  logic                wr_req_valid_i,
  output logic                wr_req_ready_o,
  input  logic [ADDR_W-1:0]   wr_req_addr_i,
  input  logic [ID_W-1:0]     wr_req_id_i,
  input  logic                wr_data_valid_i,
  output logic                wr_data_ready_o,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_we_o,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic [ID_W-1:0]     mem_req_id_o,
  output logic [DATA_W-1:0]   mem_req_data_o,
  output logic [DATA_W/8-1:0] mem_req_be_o,
  input  logic                mem_rsp_valid_i,
  output logic                mem_rsp_ready_o,
  input  logic                mem_rsp_we_i,
  input  logic [ID_W-1:0]     mem_rsp_id_i,
  input  logic [DATA_W-1:0]   mem_rsp_data_i,
  input  logic                mem_rsp_err_i,
  output logic                rd_rsp_valid_o,
  input  logic                rd_rsp_ready_i,
  output logic [ID_W-1:0]     rd_rsp_id_o,
  output logic [DATA_W-1:0]   rd_rsp_data_o,
  output logic                rd_rsp_err_o,
  output logic                wr_rsp_valid_o,
  input  logic                wr_rsp_ready_i,
  output logic [ID_W-1:0]     wr_rsp_id_o,
  output logic                wr_rsp_err_o,
  output logic                idle_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [ID_W-1:0]     id;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] be;
  } mem_req_t;

  logic       [CNT_W-1:0] cnt;
  mem_op_e                rr_ptr;
  logic                   slot_free;
  logic                   rd_elig;
  logic                   wr_elig;
  logic                   can_grant;
  logic                   pick_wr;
  logic                   rd_grant;
  logic                   wr_grant;
  logic                   rsp_fire;
  mem_req_t               req_d;
  mem_req_t               req_q;

  // Round-robin arbitration; a write needs header and data together
  always_comb begin
    rd_elig   = rd_req_valid_i;
    wr_elig   = wr_req_valid_i && wr_data_valid_i;
    can_grant = slot_free && (cnt < CNT_W'(MAX_OUTST));
    pick_wr   = wr_elig && (!rd_elig || (rr_ptr == MEM_WR));
    rd_grant  = can_grant && rd_elig && !pick_wr;
    wr_grant  = can_grant && pick_wr;
  end

  assign rd_req_ready_o  = rd_grant;
  assign wr_req_ready_o  = wr_grant;
  assign wr_data_ready_o = wr_grant;

  // Build the merged request; reads carry zero data and byte enables
  always_comb begin
    req_d = '0;
    if (wr_grant) begin
      req_d.we   = 1'b1;
      req_d.addr = wr_req_addr_i;
      req_d.id   = wr_req_id_i;
      req_d.data = wr_data_i;
      req_d.be   = wr_be_i;
    end else begin
      req_d.addr = rd_req_addr_i;
      req_d.id   = rd_req_id_i;
    end
  end

  hpdcache_mem_req_slice #(
    .req_t (mem_req_t)
  ) i_req_slice (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (rd_grant || wr_grant),
    .in_ready  (slot_free),
    .in_req    (req_d),
    .out_valid (mem_req_valid_o),
    .out_ready (mem_req_ready_i),
    .out_req   (req_q)
  );

  assign mem_req_we_o   = req_q.we;
  assign mem_req_addr_o = req_q.addr;
  assign mem_req_id_o   = req_q.id;
  assign mem_req_data_o = req_q.data;
  assign mem_req_be_o   = req_q.be;

  // Pointer only moves when both sides competed, handing priority to the loser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= MEM_RD;
    end else if (rd_elig && wr_elig && (rd_grant || wr_grant)) begin
      rr_ptr <= rd_grant ? MEM_WR : MEM_RD;
    end
  end

  // Zero-latency response demux steered by the response opcode
  always_comb begin
    rd_rsp_valid_o  = mem_rsp_valid_i && !mem_rsp_we_i;
    wr_rsp_valid_o  = mem_rsp_valid_i && mem_rsp_we_i;
    mem_rsp_ready_o = mem_rsp_we_i ? wr_rsp_ready_i : rd_rsp_ready_i;
    rsp_fire        = mem_rsp_valid_i && mem_rsp_ready_o;
  end

  assign rd_rsp_id_o   = mem_rsp_id_i;
  assign rd_rsp_data_o = mem_rsp_data_i;
  assign rd_rsp_err_o  = mem_rsp_err_i;
  assign wr_rsp_id_o   = mem_rsp_id_i;
  assign wr_rsp_err_o  = mem_rsp_err_i;

  // In-flight counter; a stray response at zero is ignored rather than wrapping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      case ({rd_grant || wr_grant, rsp_fire && (cnt != '0)})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign idle_o = (cnt == '0) && !mem_req_valid_o;

  // A response with nothing outstanding means the memory side broke protocol
  a_no_rsp_when_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_fire |-> (cnt != '0)
  );

endmodule

// File: tb/tb_hpdcache_mem_rw_mux.sv
// Directed bench for hpdcache_mem_rw_mux.
module tb_hpdcache_mem_rw_mux;

  localparam int ADDR_W = 56;
  localparam int ID_W   = 6;
  localparam int DATA_W = 512;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                rd_req_valid_i;
  logic                rd_req_ready_o;
  logic [ADDR_W-1:0]   rd_req_addr_i;
  logic [ID_W-1:0]     rd_req_id_i;
  logic                wr_req_valid_i;
  logic                wr_req_ready_o;
  logic [ADDR_W-1:0]   wr_req_addr_i;
  logic [ID_W-1:0]     wr_req_id_i;
  logic                wr_data_valid_i;
  logic                wr_data_ready_o;
  logic [DATA_W-1:0]   wr_data_i;
  logic [DATA_W/8-1:0] wr_be_i;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic                mem_req_we_o;
  logic [ADDR_W-1:0]   mem_req_addr_o;
  logic [ID_W-1:0]     mem_req_id_o;
  logic [DATA_W-1:0]   mem_req_data_o;
  logic [DATA_W/8-1:0] mem_req_be_o;
  logic                mem_rsp_valid_i;
  logic                mem_rsp_ready_o;
  logic                mem_rsp_we_i;
  logic [ID_W-1:0]     mem_rsp_id_i;
  logic [DATA_W-1:0]   mem_rsp_data_i;
  logic                mem_rsp_err_i;
  logic                rd_rsp_valid_o;
  logic                rd_rsp_ready_i;
  logic [ID_W-1:0]     rd_rsp_id_o;
  logic [DATA_W-1:0]   rd_rsp_data_o;
  logic                rd_rsp_err_o;
  logic                wr_rsp_valid_o;
  logic                wr_rsp_ready_i;
  logic [ID_W-1:0]     wr_rsp_id_o;
  logic                wr_rsp_err_o;
  logic                idle_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  hpdcache_mem_rw_mux dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rd_req_valid_i  (rd_req_valid_i),
    .rd_req_ready_o  (rd_req_ready_o),
    .rd_req_addr_i   (rd_req_addr_i),
    .rd_req_id_i     (rd_req_id_i),
    .wr_req_valid_i  (wr_req_valid_i),
    .wr_req_ready_o  (wr_req_ready_o),
    .wr_req_addr_i   (wr_req_addr_i),
    .wr_req_id_i     (wr_req_id_i),
    .wr_data_valid_i (wr_data_valid_i),
    .wr_data_ready_o (wr_data_ready_o),
    .wr_data_i       (wr_data_i),
    .wr_be_i         (wr_be_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_id_o    (mem_req_id_o),
    .mem_req_data_o  (mem_req_data_o),
    .mem_req_be_o    (mem_req_be_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .mem_rsp_we_i    (mem_rsp_we_i),
    .mem_rsp_id_i    (mem_rsp_id_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .rd_rsp_valid_o  (rd_rsp_valid_o),
    .rd_rsp_ready_i  (rd_rsp_ready_i),
    .rd_rsp_id_o     (rd_rsp_id_o),
    .rd_rsp_data_o   (rd_rsp_data_o),
    .rd_rsp_err_o    (rd_rsp_err_o),
    .wr_rsp_valid_o  (wr_rsp_valid_o),
    .wr_rsp_ready_i  (wr_rsp_ready_i),
    .wr_rsp_id_o     (wr_rsp_id_o),
    .wr_rsp_err_o    (wr_rsp_err_o),
    .idle_o          (idle_o)
  );

  // Advance to one time unit after the next rising edge
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req_valid_i  = 1'b0;
    rd_req_addr_i   = '0;
    rd_req_id_i     = '0;
    wr_req_valid_i  = 1'b0;
    wr_req_addr_i   = '0;
    wr_req_id_i     = '0;
    wr_data_valid_i = 1'b0;
    wr_data_i       = '0;
    wr_be_i         = '0;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_we_i    = 1'b0;
    mem_rsp_id_i    = '0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
    rd_rsp_ready_i  = 1'b1;
    wr_rsp_ready_i  = 1'b1;
  endtask

  // Return n read responses, then let the request stage empty out
  task automatic drain(input int n);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_we_i    = 1'b0;
    rd_rsp_ready_i  = 1'b1;
    repeat (n) next_cycle();
    mem_rsp_valid_i = 1'b0;
    next_cycle();
    n_checks++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain_idle: got %b expected 1", idle_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) next_cycle();
    n_checks++;
    if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== '0 || mem_req_id_o !== '0 || mem_req_we_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_req: got v=%b we=%b addr=%h id=%h expected all 0", mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_id_o);
    end
    n_checks++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %b expected 1", idle_o);
    end
    rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_read();
    rd_req_valid_i = 1'b1;
    rd_req_addr_i  = 56'h1000;
    rd_req_id_i    = 6'd3;
    #1;
    n_checks++;
    if (rd_req_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_rd_ready: got %b expected 1", rd_req_ready_o);
    end
    next_cycle();
    rd_req_valid_i = 1'b0;
    n_checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b0 || mem_req_addr_o !== 56'h1000 || mem_req_id_o !== 6'd3) begin
      n_fail++;
      $display("[TB] FAIL single_rd_req: got v=%b we=%b addr=%h id=%0d expected 1 0 1000 3", mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_id_o);
    end
    n_checks++;
    if (mem_req_data_o !== '0 || mem_req_be_o !== '0) begin
      n_fail++;
      $display("[TB] FAIL single_rd_payload: got be=%h expected 0 data 0", mem_req_be_o);
    end
    next_cycle();
    n_checks++;
    if (idle_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_rd_busy: got idle=%b v=%b expected 0 0", idle_o, mem_req_valid_o);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_we_i    = 1'b0;
    mem_rsp_id_i    = 6'd3;
    mem_rsp_data_i  = 512'hAB;
    mem_rsp_err_i   = 1'b0;
    #1;
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || wr_rsp_valid_o !== 1'b0 || mem_rsp_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_rd_rsp_route: got rd=%b wr=%b rdy=%b expected 1 0 1", rd_rsp_valid_o, wr_rsp_valid_o, mem_rsp_ready_o);
    end
    n_checks++;
    if (rd_rsp_id_o !== 6'd3 || rd_rsp_data_o !== 512'hAB || rd_rsp_err_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_rd_rsp_payload: got id=%0d err=%b expected 3 0", rd_rsp_id_o, rd_rsp_err_o);
    end
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_rd_idle_after: got %b expected 1", idle_o);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_we;
    exp_we = 4'b1010;
    rd_req_valid_i  = 1'b1;
    rd_req_addr_i   = 56'h2000;
    rd_req_id_i     = 6'd1;
    wr_req_valid_i  = 1'b1;
    wr_req_addr_i   = 56'h3000;
    wr_req_id_i     = 6'd2;
    wr_data_valid_i = 1'b1;
    wr_data_i       = 512'h55;
    wr_be_i         = 64'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (rd_req_ready_o !== ~exp_we[i] || wr_req_ready_o !== exp_we[i] || wr_data_ready_o !== exp_we[i]) begin
        n_fail++;
        $display("[TB] FAIL alt_grant%0d: got rd=%b wr=%b wd=%b expected wr side=%b", i, rd_req_ready_o, wr_req_ready_o, wr_data_ready_o, exp_we[i]);
      end
      next_cycle();
      n_checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== exp_we[i] || mem_req_addr_o !== (exp_we[i] ? 56'h3000 : 56'h2000)) begin
        n_fail++;
        $display("[TB] FAIL alt_req%0d: got v=%b we=%b addr=%h expected we=%b", i, mem_req_valid_o, mem_req_we_o, mem_req_addr_o, exp_we[i]);
      end
      if (exp_we[i]) begin
        n_checks++;
        if (mem_req_data_o !== 512'h55 || mem_req_be_o !== 64'hF || mem_req_id_o !== 6'd2) begin
          n_fail++;
          $display("[TB] FAIL alt_wr_payload%0d: got be=%h id=%0d expected F 2", i, mem_req_be_o, mem_req_id_o);
        end
      end
    end
    clear_inputs();
    drain(4);
  endtask

  task automatic test_write_wait();
    wr_req_valid_i = 1'b1;
    wr_req_addr_i  = 56'h6000;
    wr_req_id_i    = 6'd9;
    wr_data_i      = 512'h77;
    wr_be_i        = 64'h3;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (wr_req_ready_o !== 1'b0 || wr_data_ready_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL wr_wait_ready%0d: got hdr=%b data=%b expected 0 0", i, wr_req_ready_o, wr_data_ready_o);
      end
      next_cycle();
      n_checks++;
      if (mem_req_valid_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL wr_wait_noreq%0d: got %b expected 0", i, mem_req_valid_o);
      end
    end
    wr_data_valid_i = 1'b1;
    #1;
    n_checks++;
    if (wr_req_ready_o !== 1'b1 || wr_data_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wr_wait_accept: got hdr=%b data=%b expected 1 1", wr_req_ready_o, wr_data_ready_o);
    end
    next_cycle();
    clear_inputs();
    n_checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b1 || mem_req_addr_o !== 56'h6000 || mem_req_data_o !== 512'h77 || mem_req_be_o !== 64'h3) begin
      n_fail++;
      $display("[TB] FAIL wr_wait_req: got v=%b we=%b addr=%h be=%h expected 1 1 6000 3", mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_be_o);
    end
    drain(1);
  endtask

  task automatic test_max_outst();
    int grants;
    grants = 0;
    rd_req_valid_i = 1'b1;
    rd_req_addr_i  = 56'h7000;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rd_req_ready_o === 1'b1) grants++;
      next_cycle();
    end
    n_checks++;
    if (grants !== 8) begin
      n_fail++;
      $display("[TB] FAIL max_grants: got %0d expected 8", grants);
    end
    #1;
    n_checks++;
    if (rd_req_ready_o !== 1'b0 || idle_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_blocked: got ready=%b idle=%b expected 0 0", rd_req_ready_o, idle_o);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_we_i    = 1'b0;
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    grants = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rd_req_ready_o === 1'b1) grants++;
      next_cycle();
    end
    n_checks++;
    if (grants !== 1) begin
      n_fail++;
      $display("[TB] FAIL max_one_more: got %0d expected 1", grants);
    end
    clear_inputs();
    drain(8);
  endtask

  task automatic test_backpressure();
    mem_req_ready_i = 1'b0;
    rd_req_valid_i  = 1'b1;
    rd_req_addr_i   = 56'h4000;
    rd_req_id_i     = 6'd7;
    next_cycle();
    rd_req_addr_i   = 56'h5000;
    rd_req_id_i     = 6'd8;
    wr_req_valid_i  = 1'b1;
    wr_data_valid_i = 1'b1;
    wr_req_addr_i   = 56'h8000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (rd_req_ready_o !== 1'b0 || wr_req_ready_o !== 1'b0 || mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 56'h4000 || mem_req_id_o !== 6'd7) begin
        n_fail++;
        $display("[TB] FAIL bp_stall%0d: got rd=%b wr=%b v=%b addr=%h id=%0d expected 0 0 1 4000 7", i, rd_req_ready_o, wr_req_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_id_o);
      end
      next_cycle();
    end
    mem_req_ready_i = 1'b1;
    #1;
    n_checks++;
    if (rd_req_ready_o !== 1'b1 || wr_req_ready_o !== 1'b0 || mem_req_addr_o !== 56'h4000) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got rd=%b wr=%b addr=%h expected 1 0 4000", rd_req_ready_o, wr_req_ready_o, mem_req_addr_o);
    end
    next_cycle();
    clear_inputs();
    n_checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 56'h5000 || mem_req_id_o !== 6'd8 || mem_req_we_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_second: got v=%b addr=%h id=%0d we=%b expected 1 5000 8 0", mem_req_valid_o, mem_req_addr_o, mem_req_id_o, mem_req_we_o);
    end
    drain(2);
  endtask

  task automatic test_wr_rsp();
    wr_req_valid_i  = 1'b1;
    wr_data_valid_i = 1'b1;
    wr_req_id_i     = 6'd5;
    next_cycle();
    clear_inputs();
    wr_rsp_ready_i  = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_we_i    = 1'b1;
    mem_rsp_id_i    = 6'd5;
    mem_rsp_err_i   = 1'b1;
    #1;
    n_checks++;
    if (wr_rsp_valid_o !== 1'b1 || rd_rsp_valid_o !== 1'b0 || mem_rsp_ready_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrrsp_route: got wr=%b rd=%b rdy=%b expected 1 0 0", wr_rsp_valid_o, rd_rsp_valid_o, mem_rsp_ready_o);
    end
    n_checks++;
    if (wr_rsp_id_o !== 6'd5 || wr_rsp_err_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrrsp_payload: got id=%0d err=%b expected 5 1", wr_rsp_id_o, wr_rsp_err_o);
    end
    repeat (2) next_cycle();
    n_checks++;
    if (idle_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrrsp_held: got idle=%b expected 0", idle_o);
    end
    wr_rsp_ready_i = 1'b1;
    #1;
    n_checks++;
    if (mem_rsp_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrrsp_ready: got %b expected 1", mem_rsp_ready_o);
    end
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrrsp_idle: got %b expected 1", idle_o);
    end
  endtask

  task automatic test_reset_mid();
    rd_req_valid_i = 1'b1;
    rd_req_addr_i  = 56'h9000;
    next_cycle();
    clear_inputs();
    n_checks++;
    if (mem_req_valid_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_pre: got %b expected 1", mem_req_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== '0 || idle_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_clear: got v=%b addr=%h idle=%b expected 0 0 1", mem_req_valid_o, mem_req_addr_o, idle_o);
    end
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_write_wait();
    test_max_outst();
    test_backpressure();
    test_wr_rsp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
